// File: rtl/oam_scan_pkg.sv
// Shared types for the per-scanline OAM sprite selector: FSM states, buffer entry layout,
// sprite heights and the Y-flip row helper used when OAM_SCAN_YFLIP_EN is defined.
package oam_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_Y = 3'd1,
        ST_RD_X = 3'd2,
        ST_RD_T = 3'd3,
        ST_RD_A = 3'd4,
        ST_WR   = 3'd5,
        ST_DONE = 3'd6
    } scan_state_t;

    localparam logic [7:0] SPR_H_SHORT = 8'd8;
    localparam logic [7:0] SPR_H_TALL  = 8'd16;
    localparam logic [7:0] Y_OFFSET    = 8'd16;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] tile;
        logic [7:0] attr;
        logic [3:0] row;
    } sprite_ent_t;

    function automatic logic [3:0] row_flip(input logic [3:0] row, input logic tall);
        return (tall ? 4'd15 : 4'd7) - row;
    endfunction

endpackage

// File: rtl/oam_scan_sprite_buf.sv
// Small sprite register file: one synchronous write port, one asynchronous read port,
// cleared by the asynchronous active-low reset.
module sprite_buf #(
    parameter int DEPTH = 10,
    parameter int W     = 28
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         we,
    input  logic [3:0]   waddr,
    input  logic [W-1:0] wdata,
    input  logic [3:0]   raddr,
    output logic [W-1:0] rdata
);
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    logic [W-1:0] mem_r [DEPTH];

    // Storage array with guarded write index.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_r[k] <= '0;
            end
        end else if (we && (waddr < DEPTH_L)) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Out-of-range reads return zero rather than X.
    always_comb begin
        rdata = '0;
        if (raddr < DEPTH_L) begin
            rdata = mem_r[raddr];
        end else begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/oam_scan.sv
// Per-scanline OAM sprite selector: walks the 40 OAM entries after each start pulse and keeps
// the first MAX_SPRITES that overlap ly. Build option: OAM_SCAN_YFLIP_EN (pre-applied Y flip).
module oam_scan
    import oam_scan_pkg::*;
#(
    parameter int MAX_SPRITES = 10,
    parameter int OAM_ENTRIES = 40
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] ly,
    input  logic       obj_tall,
    input  logic       dma_active,
    output logic       oam_re,
    output logic [7:0] oam_addr,
    input  logic [7:0] oam_rdata,
    output logic       busy,
    output logic       done,
    output logic [3:0] sprite_count,
    input  logic [3:0] buf_idx,
    output logic [7:0] buf_x,
    output logic [7:0] buf_tile,
    output logic [7:0] buf_attr,
    output logic [3:0] buf_row
);
    localparam logic [5:0] LAST_IDX = 6'(OAM_ENTRIES - 1);
    localparam logic [3:0] MAX_CNT  = 4'(MAX_SPRITES);

    scan_state_t state_r;
    logic [5:0]  idx_r;
    logic [3:0]  count_r;
    logic [7:0]  ly_r;
    logic        tall_r;
    logic [3:0]  diff_r;
    logic [7:0]  x_r;
    logic [7:0]  tile_r;
    logic        oam_re_r;
    logic [7:0]  addr_r;
    logic        busy_r;
    logic        done_r;

    logic [7:0]  rdata_eff_s;
    logic [7:0]  diff_s;
    logic        hit_s;
    logic [5:0]  idx_inc_s;
    logic [3:0]  count_inc_s;
    logic        last_s;
    logic        full_s;
    logic        we_s;
    sprite_ent_t wr_ent_s;
    sprite_ent_t rd_ent_s;

    // Y-range compare, index bookkeeping and the entry about to be written.
    always_comb begin
        // DMA owns the OAM bus, so every byte looks like 0xFF and every Y misses.
        rdata_eff_s = dma_active ? 8'hFF : oam_rdata;
        diff_s      = ly_r + Y_OFFSET - rdata_eff_s;
        hit_s       = (diff_s < (tall_r ? SPR_H_TALL : SPR_H_SHORT));
        idx_inc_s   = idx_r + 6'd1;
        count_inc_s = count_r + 4'd1;
        last_s      = (idx_r == LAST_IDX);
        full_s      = (count_inc_s == MAX_CNT);
        we_s        = (state_r == ST_WR) && !start;
        wr_ent_s.x    = x_r;
        wr_ent_s.tile = tile_r;
        wr_ent_s.attr = rdata_eff_s;
        wr_ent_s.row  = diff_r;
`ifdef OAM_SCAN_YFLIP_EN
        if (rdata_eff_s[6]) begin
            wr_ent_s.row = row_flip(diff_r, tall_r);
        end else begin
            wr_ent_s.row = diff_r;
        end
        if (tall_r) begin
            wr_ent_s.tile = {tile_r[7:1], 1'b0};
        end else begin
            wr_ent_s.tile = tile_r;
        end
`endif
    end

    // Scan FSM with registered bus strobe, address and status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            idx_r    <= 6'd0;
            count_r  <= 4'd0;
            ly_r     <= 8'd0;
            tall_r   <= 1'b0;
            diff_r   <= 4'd0;
            x_r      <= 8'd0;
            tile_r   <= 8'd0;
            oam_re_r <= 1'b0;
            addr_r   <= 8'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else if (start) begin
            // A start always restarts from entry 0, discarding any write in flight.
            state_r  <= ST_RD_Y;
            idx_r    <= 6'd0;
            count_r  <= 4'd0;
            ly_r     <= ly;
            tall_r   <= obj_tall;
            oam_re_r <= 1'b1;
            addr_r   <= 8'd0;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_RD_Y: begin
                    state_r  <= ST_RD_X;
                    oam_re_r <= 1'b1;
                    addr_r   <= {idx_r, 2'b01};
                end
                ST_RD_X: begin
                    diff_r <= diff_s[3:0];
                    if (hit_s) begin
                        state_r  <= ST_RD_T;
                        oam_re_r <= 1'b1;
                        addr_r   <= {idx_r, 2'b10};
                    end else if (last_s) begin
                        state_r  <= ST_DONE;
                        oam_re_r <= 1'b0;
                        addr_r   <= 8'd0;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                    end else begin
                        state_r  <= ST_RD_Y;
                        idx_r    <= idx_inc_s;
                        oam_re_r <= 1'b1;
                        addr_r   <= {idx_inc_s, 2'b00};
                    end
                end
                ST_RD_T: begin
                    x_r      <= rdata_eff_s;
                    state_r  <= ST_RD_A;
                    oam_re_r <= 1'b1;
                    addr_r   <= {idx_r, 2'b11};
                end
                ST_RD_A: begin
                    tile_r   <= rdata_eff_s;
                    state_r  <= ST_WR;
                    oam_re_r <= 1'b0;
                    addr_r   <= 8'd0;
                end
                ST_WR: begin
                    count_r <= count_inc_s;
                    idx_r   <= idx_inc_s;
                    if (full_s || last_s) begin
                        state_r  <= ST_DONE;
                        oam_re_r <= 1'b0;
                        addr_r   <= 8'd0;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                    end else begin
                        state_r  <= ST_RD_Y;
                        oam_re_r <= 1'b1;
                        addr_r   <= {idx_inc_s, 2'b00};
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    oam_re_r <= 1'b0;
                    addr_r   <= 8'd0;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                end
            endcase
        end
    end

    sprite_buf #(
        .DEPTH (MAX_SPRITES),
        .W     (28)
    ) u_buf (
        .clock (clock),
        .reset (reset),
        .we    (we_s),
        .waddr (count_r),
        .wdata (wr_ent_s),
        .raddr (buf_idx),
        .rdata (rd_ent_s)
    );

    assign oam_re       = oam_re_r;
    assign oam_addr     = addr_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign sprite_count = count_r;
    assign buf_x        = rd_ent_s.x;
    assign buf_tile     = rd_ent_s.tile;
    assign buf_attr     = rd_ent_s.attr;
    assign buf_row      = rd_ent_s.row;

endmodule

// File: tb/tb_oam_scan.sv
// Self-checking bench for oam_scan: table of scan scenarios plus restart/reset sequences,
// expectations queued at start and compared when done rises. Honors OAM_SCAN_YFLIP_EN.
`timescale 1ns/1ps
module tb_oam_scan;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] ly = 8'd0;
    logic       obj_tall = 1'b0;
    logic       dma_active = 1'b0;
    logic       oam_re;
    logic [7:0] oam_addr;
    logic [7:0] oam_rdata = 8'd0;
    logic       busy;
    logic       done;
    logic [3:0] sprite_count;
    logic [3:0] buf_idx = 4'd0;
    logic [7:0] buf_x;
    logic [7:0] buf_tile;
    logic [7:0] buf_attr;
    logic [3:0] buf_row;

    logic [7:0] oam_mem [160];
    int         read_epoch [160];
    int         scan_id = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] tile;
        logic [7:0] attr;
        logic [3:0] row;
    } ent_t;

    typedef struct packed {
        int         cnt;
        int         cyc;
        ent_t [9:0] e;
    } exp_t;

    typedef struct {
        int         scen;
        logic [7:0] ly;
        logic       tall;
        logic       dma;
        int         cnt;
        int         cyc;
        logic [7:0] x0;
        logic [7:0] tile0;
        logic [3:0] row0;
    } vec_t;

    exp_t exp_q [$];

`ifdef OAM_SCAN_YFLIP_EN
    localparam logic [7:0] T4_TILE = 8'h42;
    localparam logic [3:0] T4_ROW  = 4'd0;
`else
    localparam logic [7:0] T4_TILE = 8'h43;
    localparam logic [3:0] T4_ROW  = 4'd15;
`endif

    oam_scan dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .ly           (ly),
        .obj_tall     (obj_tall),
        .dma_active   (dma_active),
        .oam_re       (oam_re),
        .oam_addr     (oam_addr),
        .oam_rdata    (oam_rdata),
        .busy         (busy),
        .done         (done),
        .sprite_count (sprite_count),
        .buf_idx      (buf_idx),
        .buf_x        (buf_x),
        .buf_tile     (buf_tile),
        .buf_attr     (buf_attr),
        .buf_row      (buf_row)
    );

    always #5 clock = ~clock;

    // OAM RAM model: data valid the cycle after the strobe; logs which scan touched each byte.
    always @(posedge clock) begin
        if (oam_re && oam_addr < 8'd160) begin
            oam_rdata <= oam_mem[oam_addr];
            read_epoch[oam_addr] <= scan_id;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference walk of OAM following the documented scan rules.
    function automatic exp_t model(input logic [7:0] l, input logic t, input logic d);
        exp_t       r;
        logic [7:0] y, df, tl, at;
        r = '0;
        for (int i = 0; i < 40; i++) begin
            y  = d ? 8'hFF : oam_mem[4*i];
            df = l + 8'd16 - y;
            if (df < (t ? 8'd16 : 8'd8)) begin
                tl = oam_mem[4*i+2];
                at = oam_mem[4*i+3];
                r.e[r.cnt].x    = oam_mem[4*i+1];
                r.e[r.cnt].attr = at;
                r.e[r.cnt].tile = tl;
                r.e[r.cnt].row  = df[3:0];
`ifdef OAM_SCAN_YFLIP_EN
                if (t) r.e[r.cnt].tile = {tl[7:1], 1'b0};
                if (at[6]) r.e[r.cnt].row = (t ? 4'd15 : 4'd7) - df[3:0];
`endif
                r.cyc += 5;
                r.cnt++;
                if (r.cnt == 10) break;
            end else begin
                r.cyc += 2;
            end
        end
        return r;
    endfunction

    task automatic load_scen(input int s, input logic [7:0] l);
        for (int a = 0; a < 160; a++) oam_mem[a] = 8'h00;
        case (s)
            1: begin
                oam_mem[12] = 8'd16; oam_mem[13] = 8'd8; oam_mem[14] = 8'h42; oam_mem[15] = 8'h00;
            end
            2: begin
                for (int k = 0; k < 12; k++) begin
                    oam_mem[4*k]   = 8'd20;
                    oam_mem[4*k+1] = 8'(k);
                    oam_mem[4*k+2] = 8'(8'h10 + 2*k);
                    oam_mem[4*k+3] = 8'(k);
                end
            end
            3: begin
                oam_mem[0] = 8'd20; oam_mem[1] = 8'h33; oam_mem[2] = 8'h43; oam_mem[3] = 8'h40;
            end
            5: begin
                for (int k = 0; k < 40; k++) begin
                    oam_mem[4*k] = 8'd160; oam_mem[4*k+1] = 8'h55;
                end
            end
            6: begin
                for (int k = 0; k < 40; k++) begin
                    oam_mem[4*k]   = 8'(l + 8'($urandom_range(4, 28)));
                    oam_mem[4*k+1] = 8'($urandom_range(0, 255));
                    oam_mem[4*k+2] = 8'($urandom_range(0, 255));
                    oam_mem[4*k+3] = 8'($urandom_range(0, 255));
                end
            end
            default: ;
        endcase
    endtask

    // Pulse start for one cycle; ly/obj_tall are then changed to prove they were sampled.
    task automatic pulse_start(input logic [7:0] l, input logic t);
        @(negedge clock);
        scan_id++;
        start = 1'b1; ly = l; obj_tall = t;
        @(negedge clock);
        start = 1'b0; ly = ~l; obj_tall = ~t;
        chk("busy after start", busy, 1'b1);
        chk("done after start", done, 1'b0);
    endtask

    task automatic wait_check(input string tag);
        exp_t e;
        int   cyc = 0;
        while (done !== 1'b1 && cyc < 300) begin
            @(negedge clock);
            cyc++;
        end
        e = exp_q.pop_front();
        chk({tag, " cycles"}, cyc, e.cyc);
        chk({tag, " count"}, sprite_count, e.cnt);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " oam_re"}, oam_re, 1'b0);
        for (int k = 0; k < e.cnt; k++) begin
            buf_idx = 4'(k);
            #1;
            chk({tag, " x"}, buf_x, e.e[k].x);
            chk({tag, " tile"}, buf_tile, e.e[k].tile);
            chk({tag, " attr"}, buf_attr, e.e[k].attr);
            chk({tag, " row"}, buf_row, e.e[k].row);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " oam_re"}, oam_re, 1'b0);
        chk({tag, " oam_addr"}, oam_addr, 8'd0);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " done"}, done, 1'b0);
        chk({tag, " count"}, sprite_count, 4'd0);
        for (int k = 0; k < 10; k++) begin
            buf_idx = 4'(k);
            #1;
            chk({tag, " buf"}, {buf_x, buf_tile, buf_attr, buf_row}, 28'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_zero("reset");
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        exp_t e;
        load_scen(v.scen, v.ly);
        e = model(v.ly, v.tall, v.dma);
        if (v.cnt >= 0) begin
            e.cnt = v.cnt;
            e.cyc = v.cyc;
            if (v.cnt > 0) begin
                e.e[0].x = v.x0; e.e[0].tile = v.tile0; e.e[0].row = v.row0;
            end
        end
        dma_active = v.dma;
        exp_q.push_back(e);
        pulse_start(v.ly, v.tall);
        wait_check($sformatf("vec%0d", n));
        dma_active = 1'b0;
        if (v.scen == 2 && v.cnt == 10) begin
            chk($sformatf("vec%0d entry9 read", n), read_epoch[39] == scan_id, 1'b1);
            for (int a = 40; a < 48; a++)
                chk($sformatf("vec%0d entry10-11 unread", n), read_epoch[a] == scan_id, 1'b0);
        end
    endtask

    initial begin
        vec_t tbl [10];
        vec_t rv;
        exp_t e;
        tbl[0] = '{0,   8'd0,   1'b0, 1'b0, 0,  80, 8'd0,   8'd0,    4'd0};
        tbl[1] = '{1,   8'd0,   1'b0, 1'b0, 1,  83, 8'd8,   8'h42,   4'd0};
        tbl[2] = '{2,   8'd10,  1'b0, 1'b0, 10, 50, 8'd0,   8'h10,   4'd6};
        tbl[3] = '{3,   8'd19,  1'b1, 1'b0, 1,  83, 8'h33,  T4_TILE, T4_ROW};
        tbl[4] = '{2,   8'd10,  1'b0, 1'b1, 0,  80, 8'd0,   8'd0,    4'd0};
        tbl[5] = '{2,   8'd11,  1'b0, 1'b0, 10, 50, 8'd0,   8'h10,   4'd7};
        tbl[6] = '{2,   8'd12,  1'b0, 1'b0, 0,  80, 8'd0,   8'd0,    4'd0};
        tbl[7] = '{2,   8'd12,  1'b1, 1'b0, 10, 50, 8'd0,   8'h10,   4'd8};
        tbl[8] = '{5,   8'd143, 1'b1, 1'b0, 0,  80, 8'd0,   8'd0,    4'd0};
        tbl[9] = '{2,   8'd3,   1'b1, 1'b0, 0,  80, 8'd0,   8'd0,    4'd0};

        for (int a = 0; a < 160; a++) oam_mem[a] = 8'h00;
        repeat (2) @(negedge clock);
        check_zero("por");
        reset = 1'b1;

        for (int n = 0; n < 10; n++) run_vec(tbl[n], n);

        for (int n = 0; n < 4; n++) begin
            rv = '{6, 8'($urandom_range(0, 143)), 1'($urandom_range(0, 1)), 1'b0, -1, 0, 8'd0, 8'd0, 4'd0};
            run_vec(rv, 10 + n);
        end

        // Restart landing on the WR cycle: the pending write must be dropped.
        do_reset();
        load_scen(2, 8'd0);
        pulse_start(8'd10, 1'b0);
        repeat (3) @(negedge clock);
        exp_q.push_back(model(8'd3, 1'b0, 1'b0));
        pulse_start(8'd3, 1'b0);
        wait_check("restart_wr");
        buf_idx = 4'd0;
        #1;
        chk("restart_wr discarded entry", {buf_x, buf_tile, buf_attr, buf_row}, 28'd0);

        // Restart mid-scan with a new ly: only the new line counts.
        pulse_start(8'd3, 1'b0);
        repeat (10) @(negedge clock);
        e = model(8'd10, 1'b0, 1'b0);
        exp_q.push_back(e);
        pulse_start(8'd10, 1'b0);
        wait_check("restart_ly");

        // Reset in the middle of a scan.
        pulse_start(8'd10, 1'b1);
        repeat (20) @(negedge clock);
        reset = 1'b0;
        #1;
        check_zero("midscan reset");
        @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        chk("idle after reset busy", busy, 1'b0);
        chk("idle after reset done", done, 1'b0);
        chk("idle after reset oam_re", oam_re, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
